// File: rtl/block_map_arbiter_if.sv
// ---------------------------------------------------------------------------
// block_map_arbiter_if
//   Groups every signal that connects the collision-map read arbiter to its
//   neighbours: the requesters (movement/physics blocks) on one side and the
//   single-read-port blocking RAM on the other.
//
//   Parameters
//     N       number of requesters
//     ADDR_W  blocking RAM address width
//
//   Signals
//     req       [N]      per-requester read request (level, held until gnt)
//     req_x     [10*N]   x coordinate, requester i at bits [10i+9:10i]
//     req_y     [10*N]   y coordinate, same packing
//     gnt       [N]      one-cycle grant pulse, one-hot or zero
//     rvalid    [N]      one-cycle result-valid pulse per requester
//     rdata     [N]      block flag per requester, holds last returned value
//     ram_en             read enable to the blocking RAM
//     ram_addr  [ADDR_W] read address to the blocking RAM
//     ram_dout           blocking RAM read data
//     busy               high while any read is in flight or pending
//
//   Modports
//     master  requester/RAM side: drives requests and RAM data
//     slave   arbiter side: drives grants, results and the RAM read port
// ---------------------------------------------------------------------------
interface block_map_arbiter_if #(
  parameter int N      = 4,
  parameter int ADDR_W = 20
) ();

  logic [N-1:0]      req;
  logic [10*N-1:0]   req_x;
  logic [10*N-1:0]   req_y;
  logic [N-1:0]      gnt;
  logic [N-1:0]      rvalid;
  logic [N-1:0]      rdata;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_dout;
  logic              busy;

  modport master (
    output req, req_x, req_y, ram_dout,
    input  gnt, rvalid, rdata, ram_en, ram_addr, busy
  );

  modport slave (
    input  req, req_x, req_y, ram_dout,
    output gnt, rvalid, rdata, ram_en, ram_addr, busy
  );

endinterface

// File: rtl/block_map_arbiter.sv
// ---------------------------------------------------------------------------
// block_map_arbiter
//   Shares the single-read-port blocking (collision) RAM among N movers.
//   Each cycle at most one eligible requester is granted in round-robin
//   order; its map coordinates are turned into a linear RAM address
//   (x + y*MAP_W) and launched on the RAM read port. The requester index
//   travels alongside the read through an RD_LAT-deep pipeline, and the
//   returned block flag is delivered to that requester with a one-cycle
//   rvalid pulse. Each requester has at most one read outstanding.
//
//   Parameters
//     N       number of requesters (2..8)
//     MAP_W   map width in pixels, RAM row pitch
//     MAP_H   map height in pixels
//     ADDR_W  RAM address width
//     RD_LAT  edges from the edge launching ram_addr to the edge that
//             samples ram_dout (1..4)
//
//   Ports
//     sys_clk  system clock
//     RST_N    asynchronous active-low reset
//     arb_bus  block_map_arbiter_if.slave (requests, grants, results,
//              RAM read port, busy)
//
//   Build option
//     BLKARB_OOB_SOLID_EN  when defined, coordinates with x>=MAP_W or
//       y>=MAP_H are out of bounds: they are granted and timed normally but
//       no RAM read is issued (ram_en=0) and the result is 1 (solid).
//       When undefined, coordinates are clamped to the map edge and the RAM
//       is read normally.
// ---------------------------------------------------------------------------
module block_map_arbiter #(
  parameter int N      = 4,
  parameter int MAP_W  = 960,
  parameter int MAP_H  = 500,
  parameter int ADDR_W = 20,
  parameter int RD_LAT = 2
) (
  input  logic               sys_clk,
  input  logic               RST_N,
  block_map_arbiter_if.slave arb_bus
);

  localparam int IDX_W = $clog2(N);
  localparam int LAST  = RD_LAT - 1;

  typedef logic [IDX_W-1:0] idx_t;

  // Output / control state
  logic [N-1:0]      gnt_q,      gnt_d;
  logic [N-1:0]      rvalid_q,   rvalid_d;
  logic [N-1:0]      rdata_q,    rdata_d;
  logic [N-1:0]      pending_q,  pending_d;
  logic              ram_en_q,   ram_en_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  idx_t              ptr_q,      ptr_d;

  // Read-return pipeline: stage s holds the slot launched s+1 edges earlier
  logic              vld_p_q [RD_LAT];
  logic              vld_p_d [RD_LAT];
  idx_t              idx_p_q [RD_LAT];
  idx_t              idx_p_d [RD_LAT];
  logic              oob_p_q [RD_LAT];
  logic              oob_p_d [RD_LAT];

  // Arbitration results for the current edge
  logic [N-1:0]      elig;
  logic              win_found;
  idx_t              win_idx;
  logic [9:0]        win_x;
  logic [9:0]        win_y;
  logic              win_oob;
  logic [ADDR_W-1:0] win_addr;

  // Linear RAM address; all terms are zero-extended and wrap in ADDR_W bits.
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [9:0] x,
                                                 input logic [9:0] y);
    return ADDR_W'(x) + ADDR_W'(y) * ADDR_W'(MAP_W);
  endfunction

  // Clamp a coordinate to the last valid pixel of its axis.
  function automatic logic [9:0] clamp_coord(input logic [9:0] v,
                                             input int         lim);
    return (int'(v) >= lim) ? 10'(lim - 1) : v;
  endfunction

  // A requester that already has a read in flight is never re-granted,
  // even if the result returns at this very edge.
  assign elig = arb_bus.req & ~pending_q;

  // Round-robin pick: first eligible index after the last winner.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = 1; off <= N; off++) begin
      cand = (int'(ptr_q) + off) % N;
      if (!win_found && elig[idx_t'(cand)]) begin
        win_found = 1'b1;
        win_idx   = idx_t'(cand);
      end
    end
  end

  // Coordinates of the winner, selected with constant slices.
  always_comb begin
    win_x = '0;
    win_y = '0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == idx_t'(i)) begin
        win_x = arb_bus.req_x[10*i +: 10];
        win_y = arb_bus.req_y[10*i +: 10];
      end
    end
  end

`ifdef BLKARB_OOB_SOLID_EN
  // Out-of-map lookups never touch the RAM and always read back as solid.
  assign win_oob  = (int'(win_x) >= MAP_W) || (int'(win_y) >= MAP_H);
  assign win_addr = lin_addr(win_x, win_y);
`else
  // Out-of-map lookups are pulled onto the map edge and read normally.
  assign win_oob  = 1'b0;
  assign win_addr = lin_addr(clamp_coord(win_x, MAP_W),
                             clamp_coord(win_y, MAP_H));
`endif

  // Next-state logic for grant, launch, pipeline and result registers.
  always_comb begin
    gnt_d      = '0;
    rvalid_d   = '0;
    rdata_d    = rdata_q;
    pending_d  = pending_q;
    ram_en_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ptr_d      = ptr_q;

    // Stage 0: slot launched at this edge
    vld_p_d[0] = win_found;
    idx_p_d[0] = win_idx;
    oob_p_d[0] = win_oob;
    // Stages 1..RD_LAT-1: slot rides along with the RAM read latency
    for (int s = 1; s < RD_LAT; s++) begin
      vld_p_d[s] = vld_p_q[s-1];
      idx_p_d[s] = idx_p_q[s-1];
      oob_p_d[s] = oob_p_q[s-1];
    end

    // Result stage: RAM data for the oldest slot is valid at this edge
    if (vld_p_q[LAST]) begin
      rvalid_d[idx_p_q[LAST]]  = 1'b1;
      rdata_d[idx_p_q[LAST]]   = oob_p_q[LAST] ? 1'b1 : arb_bus.ram_dout;
      pending_d[idx_p_q[LAST]] = 1'b0;
    end

    // Launch: the winner cannot be the returning requester (it was pending)
    if (win_found) begin
      gnt_d[win_idx]     = 1'b1;
      ram_en_d           = ~win_oob;
      ram_addr_d         = win_addr;
      ptr_d              = win_idx;
      pending_d[win_idx] = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      pending_q  <= '0;
      ram_en_q   <= 1'b0;
      ram_addr_q <= '0;
      // Pointer at N-1 so requester 0 has first priority after reset.
      ptr_q      <= idx_t'(N - 1);
      for (int s = 0; s < RD_LAT; s++) begin
        vld_p_q[s] <= 1'b0;
        idx_p_q[s] <= '0;
        oob_p_q[s] <= 1'b0;
      end
    end else begin
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      pending_q  <= pending_d;
      ram_en_q   <= ram_en_d;
      ram_addr_q <= ram_addr_d;
      ptr_q      <= ptr_d;
      for (int s = 0; s < RD_LAT; s++) begin
        vld_p_q[s] <= vld_p_d[s];
        idx_p_q[s] <= idx_p_d[s];
        oob_p_q[s] <= oob_p_d[s];
      end
    end
  end

  assign arb_bus.gnt      = gnt_q;
  assign arb_bus.rvalid   = rvalid_q;
  assign arb_bus.rdata    = rdata_q;
  assign arb_bus.ram_en   = ram_en_q;
  assign arb_bus.ram_addr = ram_addr_q;
  assign arb_bus.busy     = (|pending_q) | (|gnt_q) | ram_en_q;

endmodule

// File: doc/block_map_arbiter.md
Name: block_map_arbiter

Overview:
Shares the single-read-port collision (blocking) RAM among up to N movers: character, goombas and fireballs.
- Each requester presents map coordinates and a request.
- The block arbitrates round-robin, computes the linear RAM address (x + y*MAP_W), and issues at most one read per cycle, fully pipelined.
- It returns the 1-bit block flag to the issuing requester with a valid pulse.
- It sits between the movement/physics blocks and the blocking RAM instance.

Parameters:
- N, 4, number of requesters (2..8).
- MAP_W, 960, map width in pixels (RAM row pitch).
- MAP_H, 500, map height in pixels.
- ADDR_W, 20, RAM address width.
- RD_LAT, 2, clock edges from the edge that launches ram_addr to the edge at which ram_dout is sampled (1..4).

Ports:
- sys_clk  in  1  system clock.
- RST_N  in  1  reset, asynchronous, active-low.
- req  in  N  per-requester read request; level, held until gnt.
- req_x  in  10*N  x coordinate; requester i at bits [10i+9:10i].
- req_y  in  10*N  y coordinate; same packing.
- gnt  out  N  one-cycle grant pulse, one-hot or zero.
- rvalid  out  N  one-cycle result-valid pulse per requester.
- rdata  out  N  block flag per requester; holds last returned value.
- ram_en  out  1  read enable to blocking RAM.
- ram_addr  out  ADDR_W  read address to blocking RAM.
- ram_dout  in  1  blocking RAM read data.
- busy  out  1  high while any read is in flight or pending.

Behaviour:
- Reset (RST_N low, asynchronous):
  - gnt, rvalid, rdata, ram_en, busy = 0; ram_addr = 0.
  - All pending bits and pipeline stages are cleared.
  - Round-robin pointer = N-1, so requester 0 has first priority.
  - Reset mid-operation discards in-flight reads; no rvalid is emitted for them.
- Eligibility: requester i is eligible at an edge if req[i]=1 and pending[i]=0.
- Arbitration: at each edge the winner is the first eligible index scanning ptr+1, ptr+2, ... mod N. On a grant:
  - gnt[winner]=1 for exactly the following cycle.
  - ram_en=1 and ram_addr=computed address in that same cycle.
  - pending[winner] is set; ptr becomes winner.
  - If no requester is eligible: gnt=0, ram_en=0, ram_addr holds its previous value.
- Address arithmetic: req_x and req_y are zero-extended to ADDR_W; addr = x + y*MAP_W, computed in ADDR_W bits. Coordinates are sampled at the grant edge only.
- Pipeline:
  - Requester index and out-of-bounds (OOB) flag travel through an RD_LAT-deep shift register alongside the RAM read.
  - At edge g+RD_LAT (g = launch edge) the result is registered: rvalid[i]=1 for one cycle, rdata[i]=ram_dout (or OOB value), pending[i] cleared.
- Latency: req sampled at edge k gives gnt in cycle k..k+1 and rvalid in cycle k+RD_LAT..k+RD_LAT+1. With RD_LAT=2, rvalid arrives 2 cycles after gnt.
- Throughput: one grant per cycle across requesters; at most one outstanding read per requester.
- Simultaneous result return and new request for requester i at the same edge: pending is still 1 when sampled, so no grant that edge. Requester i is eligible from the next edge, giving a minimum re-request spacing of RD_LAT+1 cycles.
- req dropped before gnt: the request is withdrawn; no grant and no state change.
- req held after gnt: treated as a new request once pending clears.
- busy = OR of pending bits, or any gnt/ram_en asserted.

Optional Feature:
BLKARB_OOB_SOLID_EN
- Defined: a coordinate with x>=MAP_W or y>=MAP_H is OOB.
  - It is still granted and timed identically through the pipeline.
  - ram_en=0 for that slot; the result is rdata=1 (solid).
- Undefined: x is clamped to MAP_W-1 and y to MAP_H-1 before address computation, and the RAM is read normally.

Test Plan:
- Single request, RD_LAT=2: req[0]=1 with x=220, y=360 at edge 0 → gnt[0] in cycle 0-1, ram_addr=345820, ram_en=1; RAM returns 1 → rvalid[0] in cycle 2-3, rdata[0]=1, busy low afterwards.
- All four req held high from reset → grants in order 0,1,2,3 on consecutive cycles, then 0 again on the cycle after rvalid[0]; no requester is skipped over 40 cycles (counts differ by ≤1).
- Requester 2 re-requests continuously alone → grants spaced exactly RD_LAT+1=3 cycles apart; never a second gnt[2] while pending.
- RST_N pulled low one cycle after gnt[1] (read in flight) → all outputs 0 asynchronously; after release, no rvalid[1] appears; the next grant goes to requester 0 first.
- OOB with x=970, y=10:
  - Macro defined → ram_en=0, rvalid after 2 cycles, rdata=1.
  - Macro undefined → ram_addr = 959 + 10*960 = 10559, ram_en=1.
- req[3] pulsed for one cycle while requester 0 wins arbitration → no gnt[3], pending[3] stays 0, no rvalid[3].
